// File: rtl/auth_msg_responder.sv
// Responder side of the USB Type-C Authentication exchange: GET_DIGESTS / GET_CERTIFICATE in, DIGESTS / CERTIFICATE / ERROR out.
// Optional ERROR-response counter port err_count is built when AUTH_RSP_ERRCNT_EN is defined.
module auth_msg_responder #(
  parameter int          ADDR_W     = 10,
  parameter int          DIGEST_LEN = 32,
  parameter int          CERT_LEN   = 512,
  parameter int          MAX_CHUNK  = 64,
  parameter logic [7:0]  SLOT_MASK  = 8'h01
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_data,
  input  logic              req_last,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_last,
  output logic              st_rd,
  output logic [ADDR_W-1:0] st_addr,
  input  logic [7:0]        st_data,
`ifdef AUTH_RSP_ERRCNT_EN
  output logic [7:0]        err_count,
`endif
  output logic              busy
);

  localparam logic [1:0] ST_RX      = 2'd0;
  localparam logic [1:0] ST_PARSE   = 2'd1;
  localparam logic [1:0] ST_HDR     = 2'd2;
  localparam logic [1:0] ST_PAYLOAD = 2'd3;

  logic [1:0]        state_r, state_nx;
  logic [3:0]        cnt_r, cnt_nx;
  logic              ovl_r, ovl_nx;
  logic [7:0][7:0]   req_b_r, req_b_nx;
  logic [2:0]        hidx_r, hidx_nx;
  logic              err_r, err_nx;
  logic              cert_r, cert_nx;
  logic [7:0]        code_r, code_nx;
  logic [16:0]       rem_r, rem_nx;
  logic [ADDR_W-1:0] addr_r, addr_nx;
  logic              pend_r, pend_nx;
  logic              rsp_valid_r, rsp_valid_nx;
  logic [7:0]        rsp_data_r, rsp_data_nx;
  logic              rsp_last_r, rsp_last_nx;
  logic              ready_r, ready_nx;
  logic              busy_r, busy_nx;
  logic              st_rd_s, xfer_s;
  logic [7:0]        hdr_byte_s;
  logic [16:0]       off_s, len_s, room_s, n_s;

  assign xfer_s    = rsp_valid_r & rsp_ready;
  assign req_ready = ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_last  = rsp_last_r;
  assign st_rd     = st_rd_s;
  assign st_addr   = addr_r;
  assign busy      = busy_r;

  // Certificate chunk size: min(len, CERT_LEN-offset, MAX_CHUNK) at 17 bits
  always_comb begin
    off_s  = {1'b0, req_b_r[5], req_b_r[4]};
    len_s  = {1'b0, req_b_r[7], req_b_r[6]};
    room_s = 17'(CERT_LEN) - off_s;
    n_s    = len_s;
    if (room_s < n_s) n_s = room_s;
    else              n_s = n_s;
    if (17'(MAX_CHUNK) < n_s) n_s = 17'(MAX_CHUNK);
    else                      n_s = n_s;
  end

  // Header byte for the current header index and response kind
  always_comb begin
    hdr_byte_s = 8'h00;
    case (hidx_r[1:0])
      2'd0: hdr_byte_s = 8'h01;
      2'd1: if (err_r) hdr_byte_s = 8'h7F; else if (cert_r) hdr_byte_s = 8'h02; else hdr_byte_s = 8'h01;
      2'd2: if (err_r) hdr_byte_s = code_r; else if (cert_r) hdr_byte_s = req_b_r[2]; else hdr_byte_s = 8'h00;
      2'd3: if (err_r) hdr_byte_s = 8'h00; else if (cert_r) hdr_byte_s = 8'h00; else hdr_byte_s = SLOT_MASK;
      default: hdr_byte_s = 8'h00;
    endcase
  end

  // Next-state logic for the request/response FSM and datapath
  always_comb begin
    state_nx     = state_r;
    cnt_nx       = cnt_r;
    ovl_nx       = ovl_r;
    req_b_nx     = req_b_r;
    hidx_nx      = hidx_r;
    err_nx       = err_r;
    cert_nx      = cert_r;
    code_nx      = code_r;
    rem_nx       = rem_r;
    addr_nx      = addr_r;
    rsp_valid_nx = rsp_valid_r;
    rsp_data_nx  = rsp_data_r;
    rsp_last_nx  = rsp_last_r;
    st_rd_s      = 1'b0;
    case (state_r)
      ST_RX: begin
        if (req_valid && ready_r) begin
          if (cnt_r < 4'd8) begin
            req_b_nx[cnt_r[2:0]] = req_data;
            cnt_nx               = cnt_r + 4'd1;
          end else begin
            ovl_nx = 1'b1;
          end
          if (req_last) state_nx = ST_PARSE;
          else          state_nx = ST_RX;
        end else begin
          state_nx = ST_RX;
        end
      end
      ST_PARSE: begin
        hidx_nx  = 3'd0;
        err_nx   = 1'b1;
        cert_nx  = 1'b0;
        code_nx  = 8'h01;
        state_nx = ST_HDR;
        if (req_b_r[0] != 8'h01) begin
          code_nx = 8'h03;
        end else if (ovl_r || (cnt_r < 4'd2)) begin
          code_nx = 8'h01;
        end else if (req_b_r[1] == 8'h81) begin
          if (cnt_r == 4'd4) begin
            err_nx  = 1'b0;
            rem_nx  = 17'(DIGEST_LEN);
            addr_nx = '0;
          end else begin
            code_nx = 8'h01;
          end
        end else if (req_b_r[1] == 8'h82) begin
          // Out-of-range offset or empty length is an invalid request, not a short response
          if ((cnt_r == 4'd8) && (off_s < 17'(CERT_LEN)) && (len_s != 17'd0)) begin
            err_nx  = 1'b0;
            cert_nx = 1'b1;
            rem_nx  = n_s;
            addr_nx = ADDR_W'(DIGEST_LEN) + off_s[ADDR_W-1:0];
          end else begin
            code_nx = 8'h01;
          end
        end else begin
          code_nx = 8'h02;
        end
      end
      ST_HDR: begin
        if (hidx_r == 3'd4) begin
          if (xfer_s) begin
            rsp_valid_nx = 1'b0;
            rsp_last_nx  = 1'b0;
            if (err_r) begin
              state_nx = ST_RX;
              cnt_nx   = 4'd0;
              ovl_nx   = 1'b0;
            end else begin
              state_nx = ST_PAYLOAD;
              st_rd_s  = 1'b1;
              addr_nx  = addr_r + ADDR_W'(1);
              rem_nx   = rem_r - 17'd1;
            end
          end else begin
            state_nx = ST_HDR;
          end
        end else if (!rsp_valid_r || xfer_s) begin
          rsp_valid_nx = 1'b1;
          rsp_data_nx  = hdr_byte_s;
          rsp_last_nx  = err_r && (hidx_r == 3'd3);
          hidx_nx      = hidx_r + 3'd1;
        end else begin
          hidx_nx = hidx_r;
        end
      end
      ST_PAYLOAD: begin
        if (pend_r) begin
          rsp_valid_nx = 1'b1;
          rsp_data_nx  = st_data;
          rsp_last_nx  = (rem_r == 17'd0);
        end else if (xfer_s) begin
          rsp_valid_nx = 1'b0;
          rsp_last_nx  = 1'b0;
          if (rsp_last_r) begin
            state_nx = ST_RX;
            cnt_nx   = 4'd0;
            ovl_nx   = 1'b0;
          end else begin
            st_rd_s = 1'b1;
            addr_nx = addr_r + ADDR_W'(1);
            rem_nx  = rem_r - 17'd1;
          end
        end else begin
          state_nx = ST_PAYLOAD;
        end
      end
      default: state_nx = ST_RX;
    endcase
    pend_nx  = st_rd_s;
    ready_nx = (state_nx == ST_RX);
    busy_nx  = (state_nx != ST_RX) || (cnt_nx != 4'd0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r     <= ST_RX;
      cnt_r       <= 4'd0;
      ovl_r       <= 1'b0;
      req_b_r     <= '0;
      hidx_r      <= 3'd0;
      err_r       <= 1'b0;
      cert_r      <= 1'b0;
      code_r      <= 8'h00;
      rem_r       <= 17'd0;
      addr_r      <= '0;
      pend_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_last_r  <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cnt_r       <= cnt_nx;
      ovl_r       <= ovl_nx;
      req_b_r     <= req_b_nx;
      hidx_r      <= hidx_nx;
      err_r       <= err_nx;
      cert_r      <= cert_nx;
      code_r      <= code_nx;
      rem_r       <= rem_nx;
      addr_r      <= addr_nx;
      pend_r      <= pend_nx;
      rsp_valid_r <= rsp_valid_nx;
      rsp_data_r  <= rsp_data_nx;
      rsp_last_r  <= rsp_last_nx;
      ready_r     <= ready_nx;
      busy_r      <= busy_nx;
    end
  end

`ifdef AUTH_RSP_ERRCNT_EN
  logic [7:0] err_cnt_r;
  assign err_count = err_cnt_r;

  // Saturating count of completed ERROR responses
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_cnt_r <= 8'h00;
    end else if ((state_r == ST_HDR) && xfer_s && rsp_last_r && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'h01;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end
`endif

endmodule
